core_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the RV32I datapath: FETCH, DECODE, EXEC, MEM, WB, TRAP.
//  - Holds PC and the instruction register feeding the decoder.
//  - Gates the decoder's level write-enables (RF/DM/CSR) into single-cycle strobes.
//  - Runs valid/ready handshakes to instruction and data memory.
//  - Raises traps on illegal opcode, bus timeout and misaligned PC.

---
 rtl/core_sequencer_if.sv | 20 ++
 rtl/core_sequencer.sv | 145 ++++++++++++++
 tb/tb_core_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the core sequencer and its memories.
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP with bus timeouts,
// PC/IR ownership and single-cycle gating of the decoder's level write-enables.
module core_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    core_sequencer_if.master        bus,
    output logic [31:0]             instr,
    input  logic                    dec_rf_wen,
    input  logic                    dec_dm_wen,
    input  logic                    dec_csr_wen,
    input  logic                    dec_is_load,
    input  logic                    dec_illegal,
    input  logic [31:0]             next_pc,
    output logic [31:0]             pc,
    output logic                    rf_wen,
    output logic                    csr_wen,
    output logic                    retire,
    output logic [31:0]             instret,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [31:0] Nop          = 32'h0000_0013;
    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] wait_inc;
    logic        wb_ok;

    assign wait_inc = wait_q + 16'd1;
    assign wb_ok    = (state_q == StWb) && (next_pc[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= Nop;
            instret_q <= 32'd0;
            cause_q   <= 2'd0;
            wait_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
        end
    end

    // wait_d defaults to zero so the counter is clear on every entry to FETCH/MEM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        wait_d    = 16'd0;
        unique case (state_q)
            StFetch: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = StDecode;
                end else if (wait_inc == TimeoutLimit) begin
                    cause_d = 2'd1;
                    state_d = StTrap;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDecode: begin
                if (dec_illegal) begin
                    cause_d = 2'd0;
                    state_d = StTrap;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = (dec_dm_wen || dec_is_load) ? StMem : StWb;
            end
            StMem: begin
                if (bus.dmem_ready) begin
                    state_d = StWb;
                end else if (wait_inc == TimeoutLimit) begin
                    cause_d = 2'd2;
                    state_d = StTrap;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StWb: begin
                if (next_pc[1:0] != 2'b00) begin
                    cause_d = 2'd3;
                    state_d = StTrap;
                end else begin
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    state_d   = StFetch;
                end
            end
            StTrap: begin
                pc_d    = TRAP_VECTOR;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Requests are masked by rst so an in-flight handshake is dropped the instant reset asserts.
    assign bus.imem_req  = (state_q == StFetch) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = (state_q == StMem) && !rst;
    assign bus.dmem_we   = (state_q == StMem) && !rst && dec_dm_wen;

    assign instr      = instr_q;
    assign pc         = pc_q;
    assign rf_wen     = wb_ok && dec_rf_wen;
    assign csr_wen    = wb_ok && dec_csr_wen;
    assign retire     = wb_ok;
    assign instret    = instret_q;
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: decoder and memories are driven by hand, one step at a time.
module tb_core_sequencer;
    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        dec_rf_wen, dec_dm_wen, dec_csr_wen, dec_is_load, dec_illegal;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        rf_wen, csr_wen, retire, trap;
    logic [31:0] instret;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int vectors;
    int miscompares;

    core_sequencer_if bus ();

    core_sequencer #(
        .RESET_PC       (32'h0000_0000),
        .TRAP_VECTOR    (32'h0000_0100),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .instr       (instr),
        .dec_rf_wen  (dec_rf_wen),
        .dec_dm_wen  (dec_dm_wen),
        .dec_csr_wen (dec_csr_wen),
        .dec_is_load (dec_is_load),
        .dec_illegal (dec_illegal),
        .next_pc     (next_pc),
        .pc          (pc),
        .rf_wen      (rf_wen),
        .csr_wen     (csr_wen),
        .retire      (retire),
        .instret     (instret),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_dec(input logic rf, input logic dm, input logic csr, input logic ld,
                           input logic ill, input logic [31:0] npc);
        dec_rf_wen  = rf;
        dec_dm_wen  = dm;
        dec_csr_wen = csr;
        dec_is_load = ld;
        dec_illegal = ill;
        next_pc     = npc;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(2);

        // Reset state
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_strobes", {28'd0, rf_wen, csr_wen, retire, trap}, 32'd0);

        // addi x1,x0,5 with zero-wait imem: F,D,E,W
        rst = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0050_0093;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        settle();
        chk("addi_c0_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("addi_c0_addr", bus.imem_addr, 32'h0);
        chk("addi_c0_rf_wen", {31'd0, rf_wen}, 32'd0);
        cyc(1);
        bus.imem_ready = 1'b0;
        settle();
        chk("addi_c1_state", {29'd0, state}, 32'd1);
        chk("addi_c1_instr", instr, 32'h0050_0093);
        chk("addi_c1_imem_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(1);
        chk("addi_c2_state", {29'd0, state}, 32'd2);
        chk("addi_c2_rf_wen", {31'd0, rf_wen}, 32'd0);
        cyc(1);
        chk("addi_c3_state", {29'd0, state}, 32'd4);
        chk("addi_c3_rf_wen", {31'd0, rf_wen}, 32'd1);
        chk("addi_c3_retire", {31'd0, retire}, 32'd1);
        chk("addi_c3_csr_wen", {31'd0, csr_wen}, 32'd0);
        cyc(1);
        chk("addi_c4_state", {29'd0, state}, 32'd0);
        chk("addi_pc", pc, 32'h4);
        chk("addi_instret", instret, 32'd1);
        chk("addi_c4_strobes", {30'd0, rf_wen, retire}, 32'd0);

        // sw with dmem_ready arriving on the 4th MEM cycle
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0020_a023;
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8);
        cyc(1);
        bus.imem_ready = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.dmem_ready = 1'b1;
            settle();
            chk("sw_mem_state", {29'd0, state}, 32'd3);
            chk("sw_dmem_req", {31'd0, bus.dmem_req}, 32'd1);
            chk("sw_dmem_we", {31'd0, bus.dmem_we}, 32'd1);
            chk("sw_addr_stable", bus.imem_addr, 32'h4);
            chk("sw_mem_retire", {31'd0, retire}, 32'd0);
            cyc(1);
        end
        bus.dmem_ready = 1'b0;
        settle();
        chk("sw_wb_state", {29'd0, state}, 32'd4);
        chk("sw_wb_retire", {31'd0, retire}, 32'd1);
        chk("sw_wb_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("sw_wb_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        cyc(1);
        chk("sw_pc", pc, 32'h8);
        chk("sw_instret", instret, 32'd2);

        // jal to misaligned 0x102 -> cause 3, then vector
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0fa0_00ef;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102);
        cyc(1);
        bus.imem_ready = 1'b0;
        cyc(2);
        chk("jmis_wb_state", {29'd0, state}, 32'd4);
        chk("jmis_wb_retire", {31'd0, retire}, 32'd0);
        chk("jmis_wb_rf_wen", {31'd0, rf_wen}, 32'd0);
        cyc(1);
        chk("jmis_trap", {31'd0, trap}, 32'd1);
        chk("jmis_cause", {30'd0, trap_cause}, 32'd3);
        chk("jmis_pc_hold", pc, 32'h8);
        cyc(1);
        chk("jmis_trap_off", {31'd0, trap}, 32'd0);
        chk("jmis_pc_vec", pc, 32'h100);
        chk("jmis_instret", instret, 32'd2);

        // jal to 0x40 retires normally
        bus.imem_ready = 1'b1;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
        cyc(1);
        bus.imem_ready = 1'b0;
        cyc(2);
        chk("jal_retire", {31'd0, retire}, 32'd1);
        cyc(1);
        chk("jal_pc", pc, 32'h40);
        chk("jal_instret", instret, 32'd3);

        // Illegal opcode 7'b1111111 with level enables high -> no strobes, cause 0
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_007f;
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44);
        cyc(1);
        bus.imem_ready = 1'b0;
        settle();
        chk("ill_dec_state", {29'd0, state}, 32'd1);
        chk("ill_dec_strobes", {30'd0, rf_wen, csr_wen}, 32'd0);
        cyc(1);
        chk("ill_trap", {31'd0, trap}, 32'd1);
        chk("ill_cause", {30'd0, trap_cause}, 32'd0);
        chk("ill_trap_strobes", {30'd0, rf_wen, csr_wen}, 32'd0);
        cyc(1);
        chk("ill_pc_vec", pc, 32'h100);
        chk("ill_trap_off", {31'd0, trap}, 32'd0);

        // imem never ready: 255 wait cycles then trap cause 1
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
        cyc(254);
        chk("ito_still_fetch", {29'd0, state}, 32'd0);
        chk("ito_req_held", {31'd0, bus.imem_req}, 32'd1);
        cyc(1);
        chk("ito_trap", {31'd0, trap}, 32'd1);
        chk("ito_cause", {30'd0, trap_cause}, 32'd1);
        chk("ito_req_drop", {31'd0, bus.imem_req}, 32'd0);
        cyc(1);
        chk("ito_pc_vec", pc, 32'h100);
        chk("ito_fetch", {29'd0, state}, 32'd0);

        // Ready on the limit cycle wins over the timeout
        bus.imem_rdata = 32'h0050_0093;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
        cyc(254);
        bus.imem_ready = 1'b1;
        cyc(1);
        bus.imem_ready = 1'b0;
        settle();
        chk("rdywin_state", {29'd0, state}, 32'd1);
        chk("rdywin_trap", {31'd0, trap}, 32'd0);
        cyc(3);
        chk("rdywin_pc", pc, 32'h104);
        chk("rdywin_instret", instret, 32'd4);

        // Load with dmem never ready -> trap cause 2
        bus.imem_ready = 1'b1;
        set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h108);
        cyc(1);
        bus.imem_ready = 1'b0;
        cyc(2);
        chk("dto_mem", {29'd0, state}, 32'd3);
        chk("dto_we", {31'd0, bus.dmem_we}, 32'd0);
        cyc(255);
        chk("dto_trap", {31'd0, trap}, 32'd1);
        chk("dto_cause", {30'd0, trap_cause}, 32'd2);
        chk("dto_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        cyc(1);
        chk("dto_pc_vec", pc, 32'h100);
        chk("dto_instret", instret, 32'd4);

        // Reset asserted mid-MEM drops the request immediately
        bus.imem_ready = 1'b1;
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        cyc(1);
        bus.imem_ready = 1'b0;
        cyc(3);
        chk("rmem_req", {31'd0, bus.dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        settle();
        chk("rmem_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        chk("rmem_we_drop", {31'd0, bus.dmem_we}, 32'd0);
        cyc(2);
        rst = 1'b0;
        settle();
        chk("rmem_pc", pc, 32'h0);
        chk("rmem_instr", instr, 32'h0000_0013);
        chk("rmem_instret", instret, 32'd0);
        chk("rmem_state", {29'd0, state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
